// File: rtl/ci_block_ctrl.sv
// ci_block_ctrl: sequencing controller for the coder-interleaver datapath
// Ports:
//   clk, clear_n        clock, async active-low reset
//   k_size_6144, start  block size select and block start (IDLE only)
//   abort               sync abort back to IDLE from any state
//   byte_valid/ready    byte input handshake; shift_en is the shift-register strobe
//   k_latched           block size captured at start
//   mux_ind             serial bit index into the ci/cpii muxes
//   out_valid/ready     bit output handshake; out_last marks index K-1
//   busy, done, err_ovf status; err_ovf flags bytes offered outside LOAD
module ci_block_ctrl #(
  parameter int K_LARGE    = 6144,
  parameter int K_SMALL    = 1056,
  parameter int IDX_W      = 14,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             k_size_6144,
  input  logic             start,
  input  logic             abort,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             shift_en,
  output logic             k_latched,
  output logic [IDX_W-1:0] mux_ind,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, DONE} state_t;
  localparam logic [9:0]       NBL_M1 = 10'(K_LARGE / 8 - 1);
  localparam logic [9:0]       NBS_M1 = 10'(K_SMALL / 8 - 1);
  localparam logic [IDX_W-1:0] KL_M1  = IDX_W'(K_LARGE - 1);
  localparam logic [IDX_W-1:0] KS_M1  = IDX_W'(K_SMALL - 1);
  localparam logic [3:0]       SET_M1 = 4'(SETTLE_CYC - 1);
  state_t           state_q;
  logic [9:0]       byte_cnt_q;
  logic [3:0]       settle_cnt_q;
  logic [IDX_W-1:0] mux_ind_q;
  logic             byte_ready_q, out_valid_q, done_q, err_ovf_q, k_latched_q;
  logic [9:0]       nb_m1;
  logic [IDX_W-1:0] k_m1;
  logic             ovf_set;
  assign nb_m1      = k_latched_q ? NBL_M1 : NBS_M1;
  assign k_m1       = k_latched_q ? KL_M1 : KS_M1;
  // bytes offered while busy but not loading are dropped and flagged
  assign ovf_set    = byte_valid && state_q != IDLE && state_q != LOAD;
  assign shift_en   = byte_valid & byte_ready_q;
  assign byte_ready = byte_ready_q;
  assign k_latched  = k_latched_q;
  assign mux_ind    = mux_ind_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q & (mux_ind_q == k_m1);
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign err_ovf    = err_ovf_q;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      settle_cnt_q <= '0;
      mux_ind_q    <= '0;
      byte_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      k_latched_q  <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      settle_cnt_q <= '0;
      mux_ind_q    <= '0;
      byte_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      if (ovf_set) err_ovf_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (ovf_set) err_ovf_q <= 1'b1;
      case (state_q)
        IDLE:
          if (start && !abort) begin
            state_q      <= LOAD;
            k_latched_q  <= k_size_6144;
            byte_cnt_q   <= '0;
            err_ovf_q    <= 1'b0;
            byte_ready_q <= 1'b1;
          end
        LOAD:
          if (byte_valid) begin
            if (byte_cnt_q == nb_m1) begin
              state_q      <= SETTLE;
              byte_cnt_q   <= '0;
              settle_cnt_q <= '0;
              byte_ready_q <= 1'b0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 10'd1;
            end
          end
        SETTLE:
          if (settle_cnt_q == SET_M1) begin
            state_q      <= STREAM;
            settle_cnt_q <= '0;
            mux_ind_q    <= '0;
            out_valid_q  <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        STREAM:
          if (out_ready) begin
            if (mux_ind_q == k_m1) begin
              state_q     <= DONE;
              mux_ind_q   <= '0;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              mux_ind_q <= mux_ind_q + 1'b1;
            end
          end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ci_block_ctrl.md
Name: ci_block_ctrl

Overview:
- Sequencing controller for the coder-interleaver datapath.
- Accepts one block of byte-wise input and drives the shift-enable of the 6144-bit input shift register.
- Holds the loaded block stable while the combinational interleaver and output muxes settle.
- Generates the bit index that serialises the block onto the outi/outpii muxes, with valid/ready backpressure. Replaces the free-running address counter and ind_gen.

Parameters:
- K_LARGE, 6144: block size in bits when k_size_6144=1.
- K_SMALL, 1056: block size in bits when k_size_6144=0.
- IDX_W, 14: width of mux_ind; must satisfy 2^IDX_W > K_LARGE.
- SETTLE_CYC, 2: cycles spent in SETTLE before streaming; legal range 1..15.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- clear_n, in, 1: asynchronous active-low reset.
- k_size_6144, in, 1: block size select (1 = 6144, 0 = 1056); sampled only on start.
- start, in, 1: begin a block; honoured only in IDLE.
- abort, in, 1: synchronous abort; returns to IDLE from any state.
- byte_valid, in, 1: upstream byte present.
- byte_ready, out, 1: controller accepting bytes (high only in LOAD).
- shift_en, out, 1: shift register load strobe = byte_valid & byte_ready; combinational.
- k_latched, out, 1: k_size_6144 as captured at start.
- mux_ind, out, IDX_W: current serial bit index into the ci/cpii muxes.
- out_valid, out, 1: outi/outpii bits valid this cycle.
- out_ready, in, 1: downstream accepts current bit.
- out_last, out, 1: out_valid & (mux_ind == K-1).
- busy, out, 1: state != IDLE.
- done, out, 1: one-cycle pulse on block completion.
- err_ovf, out, 1: sticky flag for bytes offered outside LOAD while busy.

Behaviour:
- Reset (clear_n=0, async):
  - State forced to IDLE.
  - byte_ready, mux_ind, out_valid, out_last, busy, done, err_ovf, k_latched all reset to 0.
  - Internal byte counter and settle counter reset to 0.
- K = K_LARGE if k_latched else K_SMALL. NBYTES = K/8 (768 or 132). Counters sized for NBYTES_max-1 = 767 (10 bits).
- IDLE:
  - start=1 → latch k_size_6144 into k_latched, clear byte_cnt and err_ovf, go to LOAD.
  - byte_ready rises the cycle after start is sampled.
- LOAD:
  - byte_ready=1. Each cycle with byte_valid=1 produces shift_en=1 and byte_cnt+1.
  - On the accept where byte_cnt == NBYTES-1 → go to SETTLE; byte_ready=0 from the next cycle.
  - No padding shifts; exactly NBYTES strobes per block.
- SETTLE:
  - Datapath held: shift_en=0, out_valid=0. settle_cnt counts 0..SETTLE_CYC-1, then → STREAM.
  - Entering STREAM sets mux_ind=0 and out_valid=1, both registered.
- STREAM:
  - out_valid=1. If out_ready=1: when mux_ind < K-1, mux_ind+1; when mux_ind == K-1, go to DONE.
  - If out_ready=0: mux_ind holds and out_valid stays 1; no bit is skipped or repeated.
  - out_last is high exactly on index K-1 (6143 or 1055).
- DONE:
  - done=1 for one cycle, out_valid=0, mux_ind returns to 0, then → IDLE.
  - A start asserted during DONE is ignored; start must be re-asserted in IDLE.
- abort=1 in any non-IDLE state:
  - Next state IDLE; counters cleared, out_valid=0, no done pulse.
  - Abort has priority over all other transitions.
  - abort and start together in IDLE: abort wins, stay IDLE.
- start outside IDLE and changes of k_size_6144 after latching are ignored.
- byte_valid=1 while busy and not in LOAD sets err_ovf (sticky until next accepted start or reset); no shift_en is generated.
- byte_valid in IDLE is ignored and does not set err_ovf.
- Latency:
  - start → first byte_ready: 1 cycle.
  - Last byte accept → first out_valid: SETTLE_CYC+1 cycles.
  - Full 6144 block with continuous valid/ready: 1 + 768 + SETTLE_CYC + 6144 + 1 cycles, start to done inclusive.

Test Plan:
- K=6144 nominal: start with k_size_6144=1, byte_valid held 1 for 768 cycles, out_ready=1 → exactly 768 shift_en pulses; out_valid first high 3 cycles after last accept; mux_ind runs 0..6143; out_last only at 6143; done pulses once; busy low after.
- K=1056: k_size_6144=1 at start, toggled to 0 mid-LOAD, then repeated with 0 at start → first run still takes 768 bytes; second run takes 132 bytes, streams mux_ind 0..1055, out_last at 1055.
- Backpressure: out_ready toggled 1,0,0,1 repeating in STREAM → mux_ind increments only on ready cycles; every index 0..K-1 is held with out_valid=1 until accepted; no index skipped.
- Bursty input: byte_valid random 50% in LOAD → shift_en count equals 132 or 768; SETTLE entered only after the final accept.
- Abort/reset mid-operation: abort at mux_ind=100 → IDLE next cycle, out_valid=0, no done. clear_n low at byte_cnt=400 → all outputs 0 immediately. A new start afterwards completes a clean block.
- Error/ignore: byte_valid=1 during SETTLE → err_ovf=1 and no shift_en; start during STREAM → no effect; the next accepted start clears err_ovf.
